// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache-miss requesters, the memory port and
// the memory arbiter. The arbiter connects through the slave modport; the
// caches plus memory model drive the master side.
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 128
);
  // icache line-fill channel
  logic                 icache_req_in;
  logic [ADDR_BITS-1:0] icache_addr_in;
  logic                 icache_fill_out;
  logic [LINE_BITS-1:0] icache_data_out;
  // dcache fill / writeback channel
  logic                 dcache_req_in;
  logic                 dcache_we_in;
  logic [ADDR_BITS-1:0] dcache_addr_in;
  logic [LINE_BITS-1:0] dcache_wdata_in;
  logic                 dcache_fill_out;
  logic [LINE_BITS-1:0] dcache_data_out;
  // shared memory port
  logic                 mem_req_out;
  logic                 mem_we_out;
  logic [ADDR_BITS-1:0] mem_addr_out;
  logic [LINE_BITS-1:0] mem_wdata_out;
  logic [LINE_BITS-1:0] mem_rdata_in;
  // status
  logic                 busy_out;

  modport slave (
    input  icache_req_in, icache_addr_in,
    input  dcache_req_in, dcache_we_in, dcache_addr_in, dcache_wdata_in,
    input  mem_rdata_in,
    output icache_fill_out, icache_data_out,
    output dcache_fill_out, dcache_data_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output busy_out
  );

  modport master (
    output icache_req_in, icache_addr_in,
    output dcache_req_in, dcache_we_in, dcache_addr_in, dcache_wdata_in,
    output mem_rdata_in,
    input  icache_fill_out, icache_data_out,
    input  dcache_fill_out, dcache_data_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  busy_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared main-memory responder for icache fills and dcache fills/writebacks.
// One line per transaction, fixed modelled latency, dcache wins conflicts.
// Sequence per transaction: IDLE (grant) -> WAIT x MEM_LATENCY -> RESP
// (one-cycle fill pulse) -> TURN (dead cycle so a stale request held in the
// cycle after the fill is not served twice) -> IDLE.
module mem_arbiter #(
  parameter int ADDR_BITS   = 32,
  parameter int LINE_BITS   = 128,
  parameter int MEM_LATENCY = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_TURN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_NONE   = 2'd0,
    G_ICACHE = 2'd1,
    G_DCACHE = 2'd2
  } grant_t;

  // Counter reload: WAIT lasts MEM_LATENCY cycles, counting down to 0.
  localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

  state_t               r_state;
  grant_t               r_grant;
  logic [7:0]           r_cnt;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [LINE_BITS-1:0] r_wdata;
  logic [LINE_BITS-1:0] r_icache_data;
  logic [LINE_BITS-1:0] r_dcache_data;
  logic                 r_icache_fill;
  logic                 r_dcache_fill;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic                 r_busy;

  logic                 w_any_req;
  logic                 w_sel_we;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [LINE_BITS-1:0] w_sel_wdata;

  // Candidate transaction in IDLE: dcache has priority, icache never writes.
  always_comb begin
    w_any_req   = bus.dcache_req_in | bus.icache_req_in;
    w_sel_we    = 1'b0;
    w_sel_addr  = bus.icache_addr_in;
    w_sel_wdata = {LINE_BITS{1'b0}};
    if (bus.dcache_req_in) begin
      w_sel_we    = bus.dcache_we_in;
      w_sel_addr  = bus.dcache_addr_in;
      w_sel_wdata = bus.dcache_wdata_in;
    end else begin
      w_sel_we    = 1'b0;
      w_sel_addr  = bus.icache_addr_in;
      w_sel_wdata = {LINE_BITS{1'b0}};
    end
  end

  // Arbitration FSM with registered outputs; pulse outputs default low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= G_NONE;
      r_cnt         <= 8'd0;
      r_we          <= 1'b0;
      r_addr        <= {ADDR_BITS{1'b0}};
      r_wdata       <= {LINE_BITS{1'b0}};
      r_icache_data <= {LINE_BITS{1'b0}};
      r_dcache_data <= {LINE_BITS{1'b0}};
      r_icache_fill <= 1'b0;
      r_dcache_fill <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_icache_fill <= 1'b0;
      r_dcache_fill <= 1'b0;
      r_mem_we      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant   <= bus.dcache_req_in ? G_DCACHE : G_ICACHE;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_cnt     <= LAT_M1;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            // With a one-cycle latency the first WAIT cycle is also the last.
            r_mem_we  <= (LAT_M1 == 8'd0) ? w_sel_we : 1'b0;
            r_state   <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
            if (r_grant == G_DCACHE) begin
              r_dcache_fill <= 1'b1;
              r_dcache_data <= bus.mem_rdata_in;
            end else if (r_grant == G_ICACHE) begin
              r_icache_fill <= 1'b1;
              r_icache_data <= bus.mem_rdata_in;
            end else begin
              r_icache_fill <= 1'b0;
              r_dcache_fill <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
            // Write strobe is raised only for the final WAIT cycle.
            r_mem_we <= (r_cnt == 8'd1) ? r_we : 1'b0;
          end
        end
        S_RESP: begin
          r_state <= S_TURN;
        end
        S_TURN: begin
          r_grant <= G_NONE;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant   <= G_NONE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.icache_fill_out = r_icache_fill;
  assign bus.icache_data_out = r_icache_data;
  assign bus.dcache_fill_out = r_dcache_fill;
  assign bus.dcache_data_out = r_dcache_data;
  assign bus.mem_req_out     = r_mem_req;
  // A reset landing in the last WAIT cycle must not let the write through.
  assign bus.mem_we_out      = r_mem_we & rst_n;
  assign bus.mem_addr_out    = r_addr;
  assign bus.mem_wdata_out   = r_wdata;
  assign bus.busy_out        = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle expectation tables for the
// main scenarios, plus a hand-written sequence for input-hold behaviour.
module tb_mem_arbiter;
  localparam int AB = 32;
  localparam int LB = 128;

  logic clk = 1'b0;
  logic rst_n;
  bit   sel;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) if5 ();
  mem_arbiter_if #(.ADDR_BITS(AB), .LINE_BITS(LB)) if1 ();

  mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .MEM_LATENCY(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5)
  );
  mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  logic          s_mreq, s_mwe, s_ifill, s_dfill, s_busy;
  logic [AB-1:0] s_maddr;
  logic [LB-1:0] s_mwdata, s_idata, s_ddata;

  // Observe whichever DUT the current vector targets.
  always_comb begin
    if (sel) begin
      s_mreq = if1.mem_req_out;  s_mwe = if1.mem_we_out;
      s_ifill = if1.icache_fill_out; s_dfill = if1.dcache_fill_out;
      s_busy = if1.busy_out; s_maddr = if1.mem_addr_out;
      s_mwdata = if1.mem_wdata_out; s_idata = if1.icache_data_out;
      s_ddata = if1.dcache_data_out;
    end else begin
      s_mreq = if5.mem_req_out;  s_mwe = if5.mem_we_out;
      s_ifill = if5.icache_fill_out; s_dfill = if5.dcache_fill_out;
      s_busy = if5.busy_out; s_maddr = if5.mem_addr_out;
      s_mwdata = if5.mem_wdata_out; s_idata = if5.icache_data_out;
      s_ddata = if5.dcache_data_out;
    end
  end

  // Index 0 (leftmost bit) is relative cycle 0, when requests first rise.
  typedef struct {
    int            id;
    bit            sel_l1;
    logic          dwe;
    logic [AB-1:0] iaddr;
    logic [AB-1:0] daddr;
    logic [LB-1:0] wdata;
    logic [LB-1:0] rdata;
    logic [0:23]   ireq, dreq, rstn;
    logic [0:23]   mreq, mwe, ifill, dfill, busy;
  } vec_t;

  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk1(string nm, int v, int c, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d cyc%0d actual=%0b required=%0b", nm, v, c, act, exp);
    end
  endtask

  task automatic chkw(string nm, int v, int c, logic [LB-1:0] act, logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d cyc%0d actual=%h required=%h", nm, v, c, act, exp);
    end
  endtask

  task automatic drive(logic ir, logic dr, logic dw, logic [AB-1:0] ia,
                       logic [AB-1:0] da, logic [LB-1:0] wd, logic [LB-1:0] rd);
    if5.icache_req_in = ir; if5.dcache_req_in = dr; if5.dcache_we_in = dw;
    if5.icache_addr_in = ia; if5.dcache_addr_in = da;
    if5.dcache_wdata_in = wd; if5.mem_rdata_in = rd;
    if1.icache_req_in = ir; if1.dcache_req_in = dr; if1.dcache_we_in = dw;
    if1.icache_addr_in = ia; if1.dcache_addr_in = da;
    if1.dcache_wdata_in = wd; if1.mem_rdata_in = rd;
  endtask

  // Two reset cycles with idle inputs, then check the reset state.
  task automatic do_reset(int v);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 128'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_busy", v, -1, s_busy, 1'b0);
    chk1("rst_mreq", v, -1, s_mreq, 1'b0);
    chk1("rst_mwe", v, -1, s_mwe, 1'b0);
    chk1("rst_ifill", v, -1, s_ifill, 1'b0);
    chk1("rst_dfill", v, -1, s_dfill, 1'b0);
    chkw("rst_idata", v, -1, s_idata, 128'h0);
    chkw("rst_ddata", v, -1, s_ddata, 128'h0);
  endtask

  task automatic run_vec(vec_t t);
    sel = t.sel_l1;
    do_reset(t.id);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      rst_n = t.rstn[c];
      drive(t.ireq[c], t.dreq[c], t.dwe, t.iaddr, t.daddr, t.wdata, t.rdata);
      @(negedge clk);
      chk1("mem_req", t.id, c, s_mreq, t.mreq[c]);
      chk1("mem_we", t.id, c, s_mwe, t.mwe[c]);
      chk1("icache_fill", t.id, c, s_ifill, t.ifill[c]);
      chk1("dcache_fill", t.id, c, s_dfill, t.dfill[c]);
      chk1("busy", t.id, c, s_busy, t.busy[c]);
      if (t.ifill[c]) chkw("icache_data", t.id, c, s_idata, t.rdata);
      if (t.dfill[c] && !t.dwe) chkw("dcache_data", t.id, c, s_ddata, t.rdata);
      if (t.mwe[c]) begin
        chkw("mem_addr", t.id, c, {96'h0, s_maddr}, {96'h0, t.daddr});
        chkw("mem_wdata", t.id, c, s_mwdata, t.wdata);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LB-1:0] a5;
    logic [LB-1:0] r1;
    logic [LB-1:0] r2;
    a5 = {4{32'hA5A5_A5A5}};
    r1 = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    r2 = 128'hFEDC_BA98_7654_3210_1111_2222_3333_4444;
    rst_n = 1'b0;
    sel = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 128'h0);

    for (int i = 0; i < 8; i++) begin
      vecs[i].id = i; vecs[i].sel_l1 = 1'b0; vecs[i].dwe = 1'b0;
      vecs[i].iaddr = 32'h0000_1000; vecs[i].daddr = 32'h0000_2000;
      vecs[i].wdata = 128'h0; vecs[i].rdata = a5;
      vecs[i].ireq = 24'h0; vecs[i].dreq = 24'h0; vecs[i].rstn = 24'hFF_FFFF;
      vecs[i].mreq = 24'h0; vecs[i].mwe = 24'h0; vecs[i].ifill = 24'h0;
      vecs[i].dfill = 24'h0; vecs[i].busy = 24'h0;
    end
    // 0: single icache fill, latency 5
    vecs[0].ireq  = 24'b1111_1110_0000_0000_0000_0000;
    vecs[0].mreq  = 24'b0111_1100_0000_0000_0000_0000;
    vecs[0].ifill = 24'b0000_0010_0000_0000_0000_0000;
    vecs[0].busy  = 24'b0111_1111_0000_0000_0000_0000;
    // 1: same-cycle conflict, dcache first then icache
    vecs[1].rdata = r1;
    vecs[1].dreq  = 24'b1111_1110_0000_0000_0000_0000;
    vecs[1].ireq  = 24'b1111_1111_1111_1110_0000_0000;
    vecs[1].mreq  = 24'b0111_1100_0111_1100_0000_0000;
    vecs[1].dfill = 24'b0000_0010_0000_0000_0000_0000;
    vecs[1].ifill = 24'b0000_0000_0000_0010_0000_0000;
    vecs[1].busy  = 24'b0111_1111_0111_1111_0000_0000;
    // 2: dcache writeback
    vecs[2].dwe = 1'b1; vecs[2].daddr = 32'h0000_3000; vecs[2].wdata = 128'h1234;
    vecs[2].dreq  = 24'b1111_1110_0000_0000_0000_0000;
    vecs[2].mreq  = 24'b0111_1100_0000_0000_0000_0000;
    vecs[2].mwe   = 24'b0000_0100_0000_0000_0000_0000;
    vecs[2].dfill = 24'b0000_0010_0000_0000_0000_0000;
    vecs[2].busy  = 24'b0111_1111_0000_0000_0000_0000;
    // 3: icache request held through TURN, re-granted right after it
    vecs[3].ireq  = 24'b1111_1111_1111_1110_0000_0000;
    vecs[3].mreq  = 24'b0111_1100_0111_1100_0000_0000;
    vecs[3].ifill = 24'b0000_0010_0000_0010_0000_0000;
    vecs[3].busy  = 24'b0111_1111_0111_1111_0000_0000;
    // 4: reset mid-WAIT drops the transaction, a later request completes
    vecs[4].rdata = r2;
    vecs[4].ireq  = 24'b1111_0111_1111_0000_0000_0000;
    vecs[4].rstn  = 24'b1110_1111_1111_1111_1111_1111;
    vecs[4].mreq  = 24'b0111_0011_1110_0000_0000_0000;
    vecs[4].ifill = 24'b0000_0000_0001_0000_0000_0000;
    vecs[4].busy  = 24'b0111_0011_1111_1000_0000_0000;
    // 5: reset in the last WAIT cycle of a writeback suppresses the write
    vecs[5].dwe = 1'b1; vecs[5].daddr = 32'h0000_3000; vecs[5].wdata = 128'h5678;
    vecs[5].dreq  = 24'b1111_1100_0000_0000_0000_0000;
    vecs[5].rstn  = 24'b1111_1011_1111_1111_1111_1111;
    vecs[5].mreq  = 24'b0111_1100_0000_0000_0000_0000;
    vecs[5].busy  = 24'b0111_1100_0000_0000_0000_0000;
    // 6: latency 1, icache fill
    vecs[6].sel_l1 = 1'b1; vecs[6].rdata = r1;
    vecs[6].ireq  = 24'b1110_0000_0000_0000_0000_0000;
    vecs[6].mreq  = 24'b0100_0000_0000_0000_0000_0000;
    vecs[6].ifill = 24'b0010_0000_0000_0000_0000_0000;
    vecs[6].busy  = 24'b0111_0000_0000_0000_0000_0000;
    // 7: latency 1, writeback
    vecs[7].sel_l1 = 1'b1; vecs[7].dwe = 1'b1; vecs[7].wdata = 128'h9ABC;
    vecs[7].dreq  = 24'b1110_0000_0000_0000_0000_0000;
    vecs[7].mreq  = 24'b0100_0000_0000_0000_0000_0000;
    vecs[7].mwe   = 24'b0100_0000_0000_0000_0000_0000;
    vecs[7].dfill = 24'b0010_0000_0000_0000_0000_0000;
    vecs[7].busy  = 24'b0111_0000_0000_0000_0000_0000;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Hand sequence: inputs changed after grant are ignored; data outputs hold.
    sel = 1'b0;
    do_reset(8);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      drive((c >= 2 && c <= 14), (c <= 6), (c >= 2), 32'h0000_4000,
            (c >= 2) ? 32'h9999_0000 : 32'h0000_2000,
            (c >= 2) ? 128'hDEAD : 128'h77, (c >= 10) ? r2 : r1);
      @(negedge clk);
      case (c)
        3: begin
          chkw("hold_addr", 8, c, {96'h0, s_maddr}, {96'h0, 32'h0000_2000});
          chkw("hold_wdata", 8, c, s_mwdata, 128'h77);
        end
        5: chk1("hold_we", 8, c, s_mwe, 1'b0);
        6: begin
          chk1("hold_dfill", 8, c, s_dfill, 1'b1);
          chkw("hold_ddata", 8, c, s_ddata, r1);
        end
        9: chkw("hold_iaddr", 8, c, {96'h0, s_maddr}, {96'h0, 32'h0000_4000});
        14: begin
          chk1("hold_ifill", 8, c, s_ifill, 1'b1);
          chkw("hold_idata", 8, c, s_idata, r2);
          chkw("keep_ddata", 8, c, s_ddata, r1);
        end
        15: begin
          chk1("ifill_pulse", 8, c, s_ifill, 1'b0);
          chkw("keep_idata", 8, c, s_idata, r2);
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
